// File: rtl/tmds_encoder.sv
// Two-stage TMDS channel encoder: transition minimisation into q_m, then DC balancing with a running disparity.
// Build option TMDS_TERC4_EN: mode 3 emits TERC4 data-island symbols from aux; otherwise mode 3 encodes as a control symbol.
module tmds_encoder #(
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  input  logic [3:0] aux,
  output logic [9:0] tmds
);

  localparam logic [1:0] MODE_CTRL  = 2'd0;
  localparam logic [1:0] MODE_VIDEO = 2'd1;
  localparam logic [1:0] MODE_GUARD = 2'd2;
  localparam logic [1:0] MODE_TERC4 = 2'd3;

  localparam logic [9:0] CTRL_00    = 10'b1101010100;
  localparam logic [9:0] CTRL_01    = 10'b0010101011;
  localparam logic [9:0] CTRL_10    = 10'b0101010100;
  localparam logic [9:0] CTRL_11    = 10'b1010101011;
  localparam logic [9:0] GUARD_CODE = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] code;
    case (c)
      2'b00:   code = CTRL_00;
      2'b01:   code = CTRL_01;
      2'b10:   code = CTRL_10;
      default: code = CTRL_11;
    endcase
    return code;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_code(input logic [3:0] n);
    logic [9:0] code;
    case (n)
      4'h0:    code = 10'b1010011100;
      4'h1:    code = 10'b1001100011;
      4'h2:    code = 10'b1011100100;
      4'h3:    code = 10'b1011100010;
      4'h4:    code = 10'b0101110001;
      4'h5:    code = 10'b0100011110;
      4'h6:    code = 10'b0110001110;
      4'h7:    code = 10'b0100111100;
      4'h8:    code = 10'b1011001100;
      4'h9:    code = 10'b0100111001;
      4'hA:    code = 10'b0110011100;
      4'hB:    code = 10'b1011000110;
      4'hC:    code = 10'b1010001110;
      4'hD:    code = 10'b1001110001;
      4'hE:    code = 10'b0101100011;
      default: code = 10'b1011000011;
    endcase
    return code;
  endfunction
`endif

  // ---------------- Stage 1: transition minimisation ----------------
  logic [3:0] data_ones;
  logic       use_xnor;
  logic [8:0] q_m_next;
  logic [3:0] n1q_next;
  logic [3:0] n0q_next;

  assign data_ones = popcount8(data);
  assign use_xnor  = (data_ones > 4'd4) || ((data_ones == 4'd4) && !data[0]);

  // The serial XOR/XNOR chain unrolls to prefix parity; each XNOR step adds an inversion,
  // so in XNOR mode the odd-indexed bits come out inverted.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_qm
      localparam logic ODD = ((gi % 2) == 1);
      assign q_m_next[gi] = (^data[gi:0]) ^ (use_xnor & ODD);
    end
  endgenerate

  assign q_m_next[8] = ~use_xnor;
  assign n1q_next    = popcount8(q_m_next[7:0]);
  assign n0q_next    = 4'd8 - n1q_next;

  logic [8:0] q_m_reg;
  logic [3:0] n1q_reg;
  logic [3:0] n0q_reg;
  logic [1:0] mode_reg;
  logic [1:0] ctrl_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_m_reg  <= '0;
      n1q_reg  <= '0;
      n0q_reg  <= '0;
      mode_reg <= MODE_CTRL;
      ctrl_reg <= 2'b00;
    end else if (ce) begin
      q_m_reg  <= q_m_next;
      n1q_reg  <= n1q_next;
      n0q_reg  <= n0q_next;
      mode_reg <= mode;
      ctrl_reg <= ctrl;
    end
  end

`ifdef TMDS_TERC4_EN
  logic [3:0] aux_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      aux_reg <= '0;
    end else if (ce) begin
      aux_reg <= aux;
    end
  end
`else
  logic unused_aux;
  assign unused_aux = ^aux;
`endif

  // ---------------- Stage 2: DC balancing and symbol select ----------------
  logic signed [4:0] cnt_reg;
  logic signed [4:0] cnt_next;
  logic signed [4:0] diff;
  logic [9:0]        tmds_reg;
  logic [9:0]        tmds_next;

  assign diff = $signed({1'b0, n1q_reg}) - $signed({1'b0, n0q_reg});

  always_comb begin
    tmds_next = ctrl_code(ctrl_reg);
    cnt_next  = 5'sd0;
    case (mode_reg)
      MODE_VIDEO: begin
        if ((cnt_reg == 5'sd0) || (n1q_reg == n0q_reg)) begin
          tmds_next = {~q_m_reg[8], q_m_reg[8], q_m_reg[8] ? q_m_reg[7:0] : ~q_m_reg[7:0]};
          cnt_next  = q_m_reg[8] ? (cnt_reg + diff) : (cnt_reg - diff);
        end else if (((cnt_reg > 5'sd0) && (n1q_reg > n0q_reg)) ||
                     ((cnt_reg < 5'sd0) && (n0q_reg > n1q_reg))) begin
          tmds_next = {1'b1, q_m_reg[8], ~q_m_reg[7:0]};
          cnt_next  = cnt_reg + (q_m_reg[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
          tmds_next = {1'b0, q_m_reg[8], q_m_reg[7:0]};
          cnt_next  = cnt_reg - (q_m_reg[8] ? 5'sd0 : 5'sd2) + diff;
        end
      end
      MODE_GUARD: begin
        tmds_next = GUARD_CODE;
      end
      MODE_TERC4: begin
`ifdef TMDS_TERC4_EN
        tmds_next = terc4_code(aux_reg);
`else
        tmds_next = ctrl_code(ctrl_reg);
`endif
      end
      default: begin
        tmds_next = ctrl_code(ctrl_reg);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmds_reg <= CTRL_00;
      cnt_reg  <= 5'sd0;
    end else if (ce) begin
      tmds_reg <= tmds_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign tmds = tmds_reg;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed bench for tmds_encoder: two instances (CHANNEL 0 and 1) share stimulus; expected symbols are hand-computed.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [1:0] mode;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic [3:0] aux;
  logic [9:0] tmds0;
  logic [9:0] tmds1;

  always #5 clk = ~clk;

  tmds_encoder #(.CHANNEL(0)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .data(data),
    .ctrl(ctrl), .aux(aux), .tmds(tmds0)
  );

  tmds_encoder #(.CHANNEL(1)) dut_ch1 (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .data(data),
    .ctrl(ctrl), .aux(aux), .tmds(tmds1)
  );

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] G0  = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;
`ifdef TMDS_TERC4_EN
  localparam logic [9:0] M3_AUX5_C11 = 10'b0100011110;
`else
  localparam logic [9:0] M3_AUX5_C11 = C11;
`endif

  int errors = 0;
  int checks = 0;
  int tx     = 0;

  // Expected two-deep pipeline of symbols (not of encoder state): stage-1 slot and output slot.
  logic [9:0] s1_exp0, out_exp0, s1_exp1, out_exp1;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string tag, input logic c_e, input logic [1:0] m, input logic [7:0] d,
                       input logic [1:0] c, input logic [3:0] a, input logic [9:0] e0, input logic [9:0] e1);
    ce = c_e; mode = m; data = d; ctrl = c; aux = a;
    tick();
    if (c_e) begin
      out_exp0 = s1_exp0; s1_exp0 = e0;
      out_exp1 = s1_exp1; s1_exp1 = e1;
    end
    tx++;
    $display("tx %0d %s ce=%0b mode=%0d data=%h ctrl=%b aux=%h tmds0=%b tmds1=%b",
             tx, tag, c_e, m, d, c, a, tmds0, tmds1);
    check({tag, "/ch0"}, tmds0, out_exp0);
    check({tag, "/ch1"}, tmds1, out_exp1);
  endtask

  task automatic do_reset(input int cycles, input logic c_e);
    rst = 1'b1; ce = c_e; mode = 2'd1; data = 8'h5A; ctrl = 2'b11; aux = 4'hF;
    for (int i = 0; i < cycles; i++) begin
      tick();
      s1_exp0 = C00; out_exp0 = C00; s1_exp1 = C00; out_exp1 = C00;
      tx++;
      $display("tx %0d reset ce=%0b tmds0=%b tmds1=%b", tx, c_e, tmds0, tmds1);
      check("reset/ch0", tmds0, C00);
      check("reset/ch1", tmds1, C00);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; mode = 2'd0; data = 8'h00; ctrl = 2'b00; aux = 4'h0;
    s1_exp0 = C00; out_exp0 = C00; s1_exp1 = C00; out_exp1 = C00;

    do_reset(2, 1'b1);
    apply("ctrl10",   1, 2'd0, 8'h00, 2'b10, 4'h0, C10, C10);
    apply("ctrl10",   1, 2'd0, 8'h00, 2'b10, 4'h0, C10, C10);

    // Disparity walk covering all three balancing branches and both q_m paths.
    apply("v00a",     1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h100, 10'h100);
    apply("v00b",     1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h3FF, 10'h3FF);
    apply("v00c",     1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h100, 10'h100);
    apply("ctrl00",   1, 2'd0, 8'h00, 2'b00, 4'h0, C00, C00);
    apply("vFFa",     1, 2'd1, 8'hFF, 2'b00, 4'h0, 10'h200, 10'h200);
    apply("vFFb",     1, 2'd1, 8'hFF, 2'b00, 4'h0, 10'h0FF, 10'h0FF);
    apply("vFFc",     1, 2'd1, 8'hFF, 2'b00, 4'h0, 10'h0FF, 10'h0FF);
    apply("vFFd",     1, 2'd1, 8'hFF, 2'b00, 4'h0, 10'h200, 10'h200);
    apply("v10",      1, 2'd1, 8'h10, 2'b00, 4'h0, 10'h1F0, 10'h1F0);
    apply("v01a",     1, 2'd1, 8'h01, 2'b00, 4'h0, 10'h1FF, 10'h1FF);
    apply("v01b",     1, 2'd1, 8'h01, 2'b00, 4'h0, 10'h300, 10'h300);
    apply("guard",    1, 2'd2, 8'h00, 2'b00, 4'h0, G0, G1);
    apply("vF0tie",   1, 2'd1, 8'hF0, 2'b00, 4'h0, 10'h205, 10'h205);
    apply("v00neg",   1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h3FF, 10'h3FF);
    apply("mode3",    1, 2'd3, 8'h00, 2'b11, 4'h5, M3_AUX5_C11, M3_AUX5_C11);
    apply("v0Ftie",   1, 2'd1, 8'h0F, 2'b00, 4'h0, 10'h105, 10'h105);
    apply("ctrl01",   1, 2'd0, 8'h00, 2'b01, 4'h0, C01, C01);
    apply("ctrl11",   1, 2'd0, 8'h00, 2'b11, 4'h0, C11, C11);
    apply("ctrl10",   1, 2'd0, 8'h00, 2'b10, 4'h0, C10, C10);

    // Same disparity stream through ce gaps; inputs during ce=0 are junk and must be ignored.
    apply("gap00a",   1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h100, 10'h100);
    apply("gapx",     0, 2'd2, 8'hA5, 2'b01, 4'h3, 10'h000, 10'h000);
    apply("gapx",     0, 2'd3, 8'h3C, 2'b10, 4'h9, 10'h000, 10'h000);
    apply("gap00b",   1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h3FF, 10'h3FF);
    apply("gapx",     0, 2'd1, 8'hFF, 2'b11, 4'h1, 10'h000, 10'h000);
    apply("gap00c",   1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h100, 10'h100);
    apply("gapx",     0, 2'd0, 8'h77, 2'b01, 4'h6, 10'h000, 10'h000);
    apply("gapx",     0, 2'd1, 8'h01, 2'b00, 4'h2, 10'h000, 10'h000);
    apply("gapc00",   1, 2'd0, 8'h00, 2'b00, 4'h0, C00, C00);
    apply("gapc00",   1, 2'd0, 8'h00, 2'b00, 4'h0, C00, C00);

    // Reset during video with ce low: in-flight symbols are dropped and disparity restarts at 0.
    apply("pre00a",   1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h100, 10'h100);
    apply("pre00b",   1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h3FF, 10'h3FF);
    apply("preFF",    1, 2'd1, 8'hFF, 2'b00, 4'h0, 10'h200, 10'h200);
    do_reset(1, 1'b0);
    apply("post00a",  1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h100, 10'h100);
    apply("post00b",  1, 2'd1, 8'h00, 2'b00, 4'h0, 10'h3FF, 10'h3FF);
    apply("postc00",  1, 2'd0, 8'h00, 2'b00, 4'h0, C00, C00);
    apply("postc00",  1, 2'd0, 8'h00, 2'b00, 4'h0, C00, C00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
